// File: rtl/morph_pkg.sv
// morph_pkg: sequencer state encoding and default frame geometry shared with the LCD scan module
package morph_pkg;
  typedef enum logic [2:0] {IDLE, ROW, GAP, PASS_END, FIN} state_t;
  localparam int IMG_W_DEF = 630;
  localparam int IMG_H_DEF = 390;
  localparam int ADDR_W_DEF = 18;
endpackage

// File: rtl/morph_pass_sequencer_if.sv
// morph_pass_sequencer_if: job handshake plus row-BRAM read, window control and result write bundle
//   master: frame-capture/datapath side (drives start, op_dilate, num_passes)
//   slave:  sequencer side (drives busy/done, read addresses, window strobes, write address, buffer selects)
interface morph_pass_sequencer_if
  import morph_pkg::*;
#(parameter int ADDR_W = ADDR_W_DEF);
  logic start, op_dilate;
  logic [2:0] num_passes;
  logic busy, done, rd_en, rd_buf, win_clr, win_shift, wr_en, wr_buf, kernel_or, result_buf;
  logic [ADDR_W-1:0] rd_addr_top, rd_addr_mid, rd_addr_bot, wr_addr;
  modport master(
    output start, op_dilate, num_passes,
    input busy, done, rd_en, rd_addr_top, rd_addr_mid, rd_addr_bot, rd_buf,
    input win_clr, win_shift, wr_en, wr_addr, wr_buf, kernel_or, result_buf
  );
  modport slave(
    input start, op_dilate, num_passes,
    output busy, done, rd_en, rd_addr_top, rd_addr_mid, rd_addr_bot, rd_buf,
    output win_clr, win_shift, wr_en, wr_addr, wr_buf, kernel_or, result_buf
  );
endinterface

// File: rtl/morph_addr_gen.sv
// morph_addr_gen: row/column counters, running row bases and the read-to-write delay line
//   init: restart a pass at r=1,c=0   adv: ROW cycle (read issued)   nxt_row: step to the next row
//   c_first/c_last/r_last: counter boundaries for the FSM
//   rd_addr_*: three row read addresses   win_shift/wr_en/wr_addr: delayed window and write strobes
module morph_addr_gen
  import morph_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic PixelClk,
  input  logic nRST,
  input  logic init,
  input  logic adv,
  input  logic nxt_row,
  output logic c_first,
  output logic c_last,
  output logic r_last,
  output logic [ADDR_W-1:0] rd_addr_top,
  output logic [ADDR_W-1:0] rd_addr_mid,
  output logic [ADDR_W-1:0] rd_addr_bot,
  output logic win_shift,
  output logic wr_en,
  output logic [ADDR_W-1:0] wr_addr
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] W = ADDR_W'(IMG_W);
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic [ADDR_W-1:0] b_top, b_mid, b_bot;
  logic [RD_LAT:0] sv, wv;
  logic [ADDR_W-1:0] wa [RD_LAT+1];
  assign c_first = c == '0;
  assign c_last = c == CW'(IMG_W - 1);
  assign r_last = r == RW'(IMG_H - 2);
  assign rd_addr_top = b_top + ADDR_W'(c);
  assign rd_addr_mid = b_mid + ADDR_W'(c);
  assign rd_addr_bot = b_bot + ADDR_W'(c);
  assign win_shift = sv[RD_LAT-1];
  assign wr_en = wv[RD_LAT];
  assign wr_addr = wa[RD_LAT];
  always_ff @(posedge PixelClk or negedge nRST)
    if (!nRST) begin
      c <= '0;
      r <= '0;
      b_top <= '0;
      b_mid <= '0;
      b_bot <= '0;
    end else if (init) begin
      c <= '0;
      r <= RW'(1);
      b_top <= '0;
      b_mid <= W;
      b_bot <= W + W;
    end else if (nxt_row) begin
      r <= r + RW'(1);
      b_top <= b_top + W;
      b_mid <= b_mid + W;
      b_bot <= b_bot + W;
    end else if (adv)
      c <= c_last ? '0 : c + CW'(1);
  // a read at column c>=2 completes the window centred on c-1; results land RD_LAT+1 cycles later
  always_ff @(posedge PixelClk or negedge nRST)
    if (!nRST) begin
      sv <= '0;
      wv <= '0;
      for (int i = 0; i <= RD_LAT; i++) wa[i] <= '0;
    end else begin
      sv <= {sv[RD_LAT-1:0], adv};
      wv <= {wv[RD_LAT-1:0], adv && c >= CW'(2)};
      wa[0] <= rd_addr_mid - ADDR_W'(1);
      for (int i = 1; i <= RD_LAT; i++) wa[i] <= wa[i-1];
    end
endmodule

// File: rtl/morph_pass_sequencer.sv
// morph_pass_sequencer: multi-pass 3x3 erode/dilate sequencing over ping-pong 1-bit frame buffers
//   PixelClk/nRST: clock and asynchronous active-low reset
//   bus (slave): start/op_dilate/num_passes in; busy/done, row read addresses, window strobes,
//                centre write address and source/destination/result buffer selects out
module morph_pass_sequencer
  import morph_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 1
) (
  input logic PixelClk,
  input logic nRST,
  morph_pass_sequencer_if.slave bus
);
  localparam int GW = $clog2(RD_LAT + 1);
  state_t st, nx;
  logic [GW-1:0] g;
  logic [2:0] pass, npass;
  logic kop, rbuf, resb, busy, init, adv, nxt_row, c_first, c_last, r_last, g_last, more;
  assign g_last = g == GW'(RD_LAT);
  assign more = pass + 3'd1 < npass;
  assign adv = st == ROW;
  assign busy = st == ROW || st == GAP || st == PASS_END;
  assign bus.busy = busy;
  assign bus.done = st == FIN;
  assign bus.rd_en = adv;
  assign bus.win_clr = adv && c_first;
  assign bus.rd_buf = rbuf;
  assign bus.wr_buf = busy && !rbuf;
  assign bus.kernel_or = kop;
  assign bus.result_buf = resb;
  always_comb begin
    nx = st;
    init = 1'b0;
    nxt_row = 1'b0;
    case (st)
      IDLE: if (bus.start) begin
        nx = bus.num_passes == 3'd0 ? FIN : ROW;
        init = bus.num_passes != 3'd0;
      end
      ROW: nx = c_last ? GAP : ROW;
      GAP: if (g_last) begin
        nxt_row = 1'b1;
        nx = r_last ? PASS_END : ROW;
      end
      PASS_END: begin
        nx = more ? ROW : FIN;
        init = more;
      end
      default: nx = IDLE;
    endcase
  end
  always_ff @(posedge PixelClk or negedge nRST)
    if (!nRST) st <= IDLE;
    else st <= nx;
  always_ff @(posedge PixelClk or negedge nRST)
    if (!nRST) begin
      g <= '0;
      pass <= '0;
      npass <= '0;
      kop <= 1'b0;
      rbuf <= 1'b0;
      resb <= 1'b0;
    end else begin
      g <= (st == GAP && !g_last) ? g + GW'(1) : '0;
      if (st == IDLE && init) begin
        pass <= '0;
        npass <= bus.num_passes;
        kop <= bus.op_dilate;
        rbuf <= resb;
      end
      if (st == PASS_END) begin
        pass <= pass + 3'd1;
        resb <= !rbuf;
        rbuf <= !rbuf;
      end
    end
  morph_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_addr (
    .PixelClk(PixelClk),
    .nRST(nRST),
    .init(init),
    .adv(adv),
    .nxt_row(nxt_row),
    .c_first(c_first),
    .c_last(c_last),
    .r_last(r_last),
    .rd_addr_top(bus.rd_addr_top),
    .rd_addr_mid(bus.rd_addr_mid),
    .rd_addr_bot(bus.rd_addr_bot),
    .win_shift(bus.win_shift),
    .wr_en(bus.wr_en),
    .wr_addr(bus.wr_addr)
  );
endmodule

// File: tb/tb_morph_pass_sequencer.sv
// tb_morph_pass_sequencer: RD_LAT=1 and RD_LAT=3 sequencers checked against a frame-level timing model
`timescale 1ns/1ps
module tb_morph_pass_sequencer;
  localparam int W = 8, H = 5, AW = 8;
  logic clk = 0, nrst = 0, start = 0, op = 0, clr = 0, tst2 = 0;
  logic [2:0] np = 0;
  int chk_pt = 0, cyc = 0, n_chk = 0, n_ok = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  morph_pass_sequencer_if #(.ADDR_W(AW)) bi [2] ();
  task automatic chk(input int l, input string nm, input longint a, input longint e);
    n_chk++;
    if (a == e) n_ok++;
    else $display("FAIL L%0d %s: got %0d expected %0d", l, nm, a, e);
  endtask
  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int L = (g == 0) ? 1 : 3;
    localparam int RL = W + L + 1;
    localparam int P = (H - 2) * RL + 1;
    int exp_a [18] = '{9, 10, 11, 12, 13, 14, 17, 18, 19, 20, 21, 22, 25, 26, 27, 28, 29, 30};
    logic act = 0, sbuf = 0, rbuf = 0, kop = 0;
    int k = 0, npj = 0, p, o, q, r;
    logic eb, ed, row, rb, er, ew;
    int n_rd = 0, n_wr = 0, n_done = 0, n_busy = 0, f_rd = -1, f_wr = -1;
    int t_busy = -1, t_done = -1, t_st = -1, last_rd = -1, gap = -1;
    logic [2:0] wbs = 0;
    logic [4*AW+9:0] outs;
    assign bi[g].start = start;
    assign bi[g].op_dilate = op;
    assign bi[g].num_passes = np;
    assign outs = {bi[g].busy, bi[g].done, bi[g].rd_en, bi[g].rd_addr_top, bi[g].rd_addr_mid,
                   bi[g].rd_addr_bot, bi[g].rd_buf, bi[g].win_clr, bi[g].win_shift, bi[g].wr_en,
                   bi[g].wr_addr, bi[g].wr_buf, bi[g].kernel_or, bi[g].result_buf};
    morph_pass_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_LAT(L)) dut (
      .PixelClk(clk), .nRST(nrst), .bus(bi[g])
    );
    // job model: k counts cycles since busy rose; the job spans npj passes of P cycles, then done
    initial forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        act = 0; k = 0; npj = 0; sbuf = 0; rbuf = 0; kop = 0;
      end else if (act) begin
        if (k == npj * P) begin act = 0; rbuf = sbuf ^ npj[0]; end
        else k++;
      end else if (start) begin
        act = 1; k = 0; npj = int'(np); sbuf = rbuf;
        if (np != 0) kop = op;
      end
    end
    initial forever begin
      @(negedge clk);
      if (!nrst) chk(L, "reset_outs", longint'(outs), 0);
      else begin
        p = k / P; o = k % P; q = o % RL; r = o / RL + 1;
        eb = act && k < npj * P;
        ed = act && k == npj * P;
        row = eb && o != P - 1;
        rb = act ? sbuf ^ p[0] : rbuf;
        er = row && q < W;
        ew = row && q >= L + 3 && q <= W + L;
        chk(L, "busy", bi[g].busy, eb);
        chk(L, "done", bi[g].done, ed);
        chk(L, "rd_en", bi[g].rd_en, er);
        chk(L, "win_clr", bi[g].win_clr, row && q == 0);
        chk(L, "win_shift", bi[g].win_shift, row && q >= L && q < W + L);
        chk(L, "wr_en", bi[g].wr_en, ew);
        chk(L, "rd_buf", bi[g].rd_buf, rb);
        chk(L, "wr_buf", bi[g].wr_buf, eb && !rb);
        chk(L, "result_buf", bi[g].result_buf, rb);
        chk(L, "kernel_or", bi[g].kernel_or, kop);
        if (er) begin
          chk(L, "rd_addr_top", bi[g].rd_addr_top, (r - 1) * W + q);
          chk(L, "rd_addr_mid", bi[g].rd_addr_mid, r * W + q);
          chk(L, "rd_addr_bot", bi[g].rd_addr_bot, (r + 1) * W + q);
        end
        if (ew) chk(L, "wr_addr", bi[g].wr_addr, r * W + q - L - 2);
      end
    end
    initial forever begin
      @(negedge clk);
      if (clr) begin
        n_rd = 0; n_wr = 0; n_done = 0; n_busy = 0; f_rd = -1; f_wr = -1;
        t_busy = -1; t_done = -1; t_st = -1; last_rd = -1; gap = -1; wbs = 0;
      end else if (nrst) begin
        if (start && t_st < 0) t_st = cyc;
        if (bi[g].busy) begin n_busy++; if (t_busy < 0) t_busy = cyc; end
        if (bi[g].done) begin n_done++; if (t_done < 0) t_done = cyc; end
        if (bi[g].rd_en) begin
          if (last_rd >= 0 && cyc - last_rd > 1 && gap < 0) gap = cyc - last_rd - 1;
          last_rd = cyc; n_rd++;
          if (f_rd < 0) f_rd = cyc;
        end
        if (bi[g].wr_en) begin
          if (f_wr < 0) f_wr = cyc;
          if (n_wr % 18 == 0 && n_wr < 54) wbs[n_wr / 18] = bi[g].wr_buf;
          if (tst2 && n_wr < 18) chk(L, "t2_wr_addr", bi[g].wr_addr, exp_a[n_wr]);
          n_wr++;
        end
      end
      case (chk_pt)
        4: begin
          chk(L, "t4_busy", n_busy, 0); chk(L, "t4_rd", n_rd, 0); chk(L, "t4_wr", n_wr, 0);
          chk(L, "t4_done", n_done, 1); chk(L, "t4_done_lat", t_done - t_st, 1);
        end
        2: begin
          chk(L, "t2_writes", n_wr, 18); chk(L, "t2_done", n_done, 1);
          chk(L, "t2_first_wr", f_wr - f_rd, (L == 1) ? 4 : 6);
          chk(L, "t2_busy_to_done", t_done - t_busy, (L == 1) ? 31 : 37);
          chk(L, "t2_gap", gap, (L == 1) ? 2 : 4);
          chk(L, "t2_result_buf", bi[g].result_buf, 1);
        end
        3: begin
          chk(L, "t3_writes", n_wr, 54); chk(L, "t3_done", n_done, 1);
          chk(L, "t3_wr_bufs", wbs, 3'b101); chk(L, "t3_result_buf", bi[g].result_buf, 1);
          chk(L, "t3_kernel_or", bi[g].kernel_or, 1);
        end
        5: begin
          chk(L, "t5_done", n_done, 1); chk(L, "t5_writes", n_wr, 36);
          chk(L, "t5_busy", n_busy, (L == 1) ? 62 : 74); chk(L, "t5_kernel_or", bi[g].kernel_or, 1);
        end
        1: begin
          chk(L, "t1_done", n_done, 0); chk(L, "t1_wr", n_wr, 0);
          chk(L, "t1_rd", n_rd, 0); chk(L, "t1_busy", n_busy, 0);
        end
        default: ;
      endcase
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic go(input logic [2:0] pn, input logic o);
    np = pn; op = o; start = 1;
    tick(1);
    start = 0;
  endtask
  task automatic clear();
    clr = 1; tick(1); clr = 0;
  endtask
  task automatic point(input int n);
    chk_pt = n; tick(1); chk_pt = 0;
  endtask
  task automatic wait_idle();
    int b = 0;
    while ((bi[0].busy || bi[0].done || bi[1].busy || bi[1].done) && b < 1000) begin
      tick(1);
      b++;
    end
    chk(0, "idle_timeout", b < 1000, 1);
    tick(2);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    tick(3); nrst = 1; tick(2);
    clear(); go(0, 1); wait_idle(); point(4);
    clear(); tst2 = 1; go(1, 0); wait_idle(); tst2 = 0; point(2);
    nrst = 0; tick(2); nrst = 1; tick(2);
    clear(); go(3, 1); wait_idle(); point(3);
    clear(); go(2, 1); tick(20); op = 0; go(3, 0);
    for (int i = 0; i < 1000 && !bi[0].done; i++) @(negedge clk);
    #1 start = 1;
    tick(1);
    start = 0;
    wait_idle(); tick(5); point(5);
    clear(); go(1, 0); tick(5);
    nrst = 0;
    #1;
    chk(1, "async_rst", {bi[0].busy, bi[0].rd_en, bi[0].win_shift, bi[0].wr_en, bi[0].rd_addr_mid, bi[0].wr_addr}, 0);
    chk(3, "async_rst", {bi[1].busy, bi[1].rd_en, bi[1].win_shift, bi[1].wr_en, bi[1].rd_addr_mid, bi[1].wr_addr}, 0);
    tick(2); nrst = 1;
    clear(); tick(40); point(1);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
